fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, program-counter width in bits.
REQ-002 SHALL have parameter IR_WIDTH, default 32, instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port I_CLOCK  in  1  single clock; all state updates on negedge I_CLOCK.
REQ-006 SHALL have port I_RESET  in  1  synchronous, active-high reset.
REQ-007 SHALL have port I_BranchPC  in  PC_WIDTH  redirect target address.
REQ-008 SHALL have port I_BranchAddrSelect  in  1  redirect strobe, one cycle.
REQ-009 SHALL have port I_BranchStallSignal  in  1  inhibits issuing new memory requests.
REQ-010 SHALL have port I_DepStallSignal  in  1  decode not accepting; head not consumed.
REQ-011 SHALL have port O_MemReq  out  1  memory read request, one cycle per request.
REQ-012 SHALL have port O_MemAddr  out  PC_WIDTH  word-aligned byte address of request.
REQ-013 SHALL have port I_MemValid  in  1  response strobe, latency >=1 cycle after request.
REQ-014 SHALL have port I_MemData  in  IR_WIDTH  response instruction.
REQ-015 SHALL have port O_PC  out  PC_WIDTH  head entry address+4.
REQ-016 SHALL have port O_IR  out  IR_WIDTH  head entry instruction.
REQ-017 SHALL have port O_FetchStall  out  1  high when no valid head entry (downstream treats as NOP).

Function
REQ-018 SHALL keep at most one outstanding memory request.
REQ-019 SHALL implement FSM IDLE, WAIT, DROP; IDLE->WAIT on issue; WAIT->IDLE on I_MemValid; WAIT->DROP on redirect; DROP->IDLE on I_MemValid.
REQ-020 SHALL issue (O_MemReq=1, O_MemAddr=fetch PC) in IDLE only when !I_BranchStallSignal, !I_BranchAddrSelect and (count+1)<=DEPTH counting the would-be entry.
REQ-021 SHALL advance fetch PC by 4 on each issue, wrapping modulo 2^PC_WIDTH.
REQ-022 SHALL enqueue {request address+4, I_MemData} on I_MemValid in WAIT; O_FetchStall falls the following cycle if queue was empty.
REQ-023 SHALL discard the I_MemValid response received in DROP.
REQ-024 SHALL dequeue head when O_FetchStall=0 and I_DepStallSignal=0; simultaneous enqueue+dequeue keeps count unchanged.
REQ-025 SHALL on I_BranchAddrSelect flush all entries, load fetch PC with I_BranchPC, assert O_FetchStall next cycle; redirect overrides dequeue, enqueue and issue in the same cycle.
REQ-026 SHALL treat a response coinciding with a redirect as stale and discard it, FSM to IDLE.
REQ-027 SHALL use log2(DEPTH)+1-bit read/write pointers; full when MSBs differ and remaining bits equal, empty when equal; wrap silently.
REQ-028 SHALL hold O_PC and O_IR stable while I_DepStallSignal=1.
REQ-029 SHALL drive O_IR=FF000000 (hex, NOP) and O_FetchStall=1 whenever queue empty.

Reset
REQ-030 SHALL on I_RESET=1 at negedge: FSM=IDLE, queue empty, fetch PC=RESET_PC, O_MemReq=0, O_PC=RESET_PC+4, O_IR=FF000000, O_FetchStall=1.
REQ-031 SHALL discard a response arriving in the first cycle after reset deasserts if a request was outstanding when reset asserted.

Configuration
REQ-032 SHALL, with FETCH_QUEUE_STATS_EN defined, add port O_StallCount  out  16  count of cycles with O_FetchStall=1 after reset, saturating at FFFF, cleared by I_RESET.
REQ-033 SHALL, without FETCH_QUEUE_STATS_EN, omit O_StallCount and its counter entirely.

Verification
REQ-034 Reset, memory latency 1, no stalls -> requests at 0,4,8,...; first O_FetchStall=0 with O_PC=4, O_IR=mem[0]; thereafter one instruction per two cycles.
REQ-035 I_DepStallSignal held high 10 cycles -> queue fills to DEPTH=4, O_MemReq stops, O_PC/O_IR unchanged; release -> entries drain in order.
REQ-036 Redirect to 0x40 while request to 0x8 outstanding -> 0x8 response discarded, next request addr 0x40, next valid O_PC=0x44.
REQ-037 Redirect coinciding with I_MemValid and head dequeue -> queue empty next cycle, response dropped, O_FetchStall=1.
REQ-038 Fetch PC at FFFC (PC_WIDTH=16) -> next request 0x0000, O_PC for entry = 0x0000.
REQ-039 With FETCH_QUEUE_STATS_EN, 5 empty cycles after reset -> O_StallCount=5; mid-run I_RESET -> 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory read, DEPTH-entry {pc+4, ir} FIFO, redirect flush.
// Optional stall-cycle counter port O_StallCount is built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
   parameter int PC_WIDTH = 16,
   parameter int IR_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                I_CLOCK,
   input  logic                I_RESET,
   input  logic [PC_WIDTH-1:0] I_BranchPC,
   input  logic                I_BranchAddrSelect,
   input  logic                I_BranchStallSignal,
   input  logic                I_DepStallSignal,
   output logic                O_MemReq,
   output logic [PC_WIDTH-1:0] O_MemAddr,
   input  logic                I_MemValid,
   input  logic [IR_WIDTH-1:0] I_MemData,
   output logic [PC_WIDTH-1:0] O_PC,
   output logic [IR_WIDTH-1:0] O_IR,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [15:0]         O_StallCount,
`endif
   output logic                O_FetchStall
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [IR_WIDTH-1:0] NOP_IR = IR_WIDTH'(32'hFF000000);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t state, stateNext;
   logic [PC_WIDTH-1:0] fetchPc, reqAddr;
   logic [AW:0] wrPtr, rdPtr;
   logic [PC_WIDTH-1:0] pcMem [DEPTH];
   logic [IR_WIDTH-1:0] irMem [DEPTH];
   logic empty, full, issue, enq, deq;

   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) state <= IDLE;
      else         state <= stateNext;
   end

   // A response that lands together with a redirect is stale, so it returns to IDLE without enqueueing.
   always_comb begin
      stateNext = state;
      issue = 1'b0;
      enq = 1'b0;
      case (state)
         IDLE: begin
            if (!I_BranchStallSignal && !I_BranchAddrSelect && !full) begin
               issue = 1'b1;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (I_MemValid) begin
               stateNext = IDLE;
               enq = !I_BranchAddrSelect;
            end else if (I_BranchAddrSelect) begin
               stateNext = DROP;
            end
         end
         DROP: begin
            if (I_MemValid) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      deq = !empty && !I_DepStallSignal && !I_BranchAddrSelect;
   end

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         wrPtr <= '0;
         rdPtr <= '0;
         fetchPc <= RESET_PC;
         reqAddr <= RESET_PC;
      end else if (I_BranchAddrSelect) begin
         rdPtr <= wrPtr;
         fetchPc <= I_BranchPC;
      end else begin
         if (issue) begin
            fetchPc <= fetchPc + PC_WIDTH'(4);
            reqAddr <= fetchPc;
         end
         if (enq) wrPtr <= wrPtr + 1'b1;
         if (deq) rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(negedge I_CLOCK) begin
      if (enq && !I_RESET) begin
         pcMem[wrPtr[AW-1:0]] <= reqAddr + PC_WIDTH'(4);
         irMem[wrPtr[AW-1:0]] <= I_MemData;
      end
   end

   assign O_MemReq = issue && !I_RESET;
   assign O_MemAddr = fetchPc;
   assign O_FetchStall = empty;
   assign O_PC = empty ? RESET_PC + PC_WIDTH'(4) : pcMem[rdPtr[AW-1:0]];
   assign O_IR = empty ? NOP_IR : irMem[rdPtr[AW-1:0]];

`ifdef FETCH_QUEUE_STATS_EN
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) O_StallCount <= '0;
      else if (empty && O_StallCount != 16'hFFFF) O_StallCount <= O_StallCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model and a simple memory responder.
// Checks O_StallCount as well when FETCH_QUEUE_STATS_EN is defined.
module tb_fetch_queue;

   localparam int PW = 16;
   localparam int IW = 32;
   localparam int DEPTH = 4;
   localparam logic [PW-1:0] RESET_PC = 16'h0000;

   logic I_CLOCK = 1'b0;
   logic I_RESET, I_BranchAddrSelect, I_BranchStallSignal, I_DepStallSignal, I_MemValid;
   logic [PW-1:0] I_BranchPC;
   logic [IW-1:0] I_MemData;
   logic O_MemReq, O_FetchStall;
   logic [PW-1:0] O_MemAddr, O_PC;
   logic [IW-1:0] O_IR;
`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] O_StallCount;
`endif

   fetch_queue #(.PC_WIDTH(PW), .IR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .I_CLOCK(I_CLOCK),
      .I_RESET(I_RESET),
      .I_BranchPC(I_BranchPC),
      .I_BranchAddrSelect(I_BranchAddrSelect),
      .I_BranchStallSignal(I_BranchStallSignal),
      .I_DepStallSignal(I_DepStallSignal),
      .O_MemReq(O_MemReq),
      .O_MemAddr(O_MemAddr),
      .I_MemValid(I_MemValid),
      .I_MemData(I_MemData),
      .O_PC(O_PC),
      .O_IR(O_IR),
`ifdef FETCH_QUEUE_STATS_EN
      .O_StallCount(O_StallCount),
`endif
      .O_FetchStall(O_FetchStall)
   );

   always #5 I_CLOCK = ~I_CLOCK;

   typedef struct {
      logic [PW-1:0] pc;
      logic [IW-1:0] ir;
   } entry_t;

   entry_t mq[$];
   logic [PW-1:0] mFetchPc, mReqAddr;
   logic mOut, mStale;
   int mStallCnt;
   int dueQ[$];
   logic [PW-1:0] addrQ[$];
   int cycle = 0;
   int testsRun = 0;
   int testsFailed = 0;

   function automatic logic [IW-1:0] memWord(input logic [PW-1:0] addr);
      return {~addr, addr} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // One clock: drive inputs, deliver any due memory response, compare, then advance the model.
   task automatic applyStimulus(input logic rst, input logic br, input logic [PW-1:0] brPc,
                                input logic brStall, input logic depStall, input int lat);
      logic expReq, expStall, deqNow;
      logic [PW-1:0] expPc;
      logic [IW-1:0] expIr;
      entry_t e;
      int due;
      @(posedge I_CLOCK);
      #1;
      cycle++;
      I_RESET = rst;
      I_BranchAddrSelect = br;
      I_BranchPC = brPc;
      I_BranchStallSignal = brStall;
      I_DepStallSignal = depStall;
      I_MemValid = 1'b0;
      I_MemData = $urandom;
      if (dueQ.size() > 0 && dueQ[0] == cycle) begin
         I_MemValid = 1'b1;
         I_MemData = memWord(addrQ[0]);
         void'(dueQ.pop_front());
         void'(addrQ.pop_front());
      end
      #1;
      expStall = (mq.size() == 0);
      expPc = expStall ? RESET_PC + 16'd4 : mq[0].pc;
      expIr = expStall ? 32'hFF000000 : mq[0].ir;
      expReq = !rst && !mOut && !brStall && !br && (mq.size() < DEPTH);
      if (!rst) begin
         checkOutput("fetchStall", O_FetchStall, expStall);
         checkOutput("headPc", O_PC, expPc);
         checkOutput("headIr", O_IR, expIr);
         checkOutput("memReq", O_MemReq, expReq);
         if (expReq) checkOutput("memAddr", O_MemAddr, mFetchPc);
`ifdef FETCH_QUEUE_STATS_EN
         checkOutput("stallCount", O_StallCount, mStallCnt);
`endif
      end
      if (expReq) begin
         due = cycle + lat;
         if (dueQ.size() > 0 && dueQ[$] >= due) due = dueQ[$] + 1;
         dueQ.push_back(due);
         addrQ.push_back(mFetchPc);
      end
      if (rst) begin
         mq.delete();
         mFetchPc = RESET_PC;
         mOut = 1'b0;
         mStale = 1'b0;
         mStallCnt = 0;
      end else begin
         if (expStall && mStallCnt < 16'hFFFF) mStallCnt++;
         if (br) begin
            mq.delete();
            mFetchPc = brPc;
            if (mOut) begin
               if (I_MemValid) begin
                  mOut = 1'b0;
                  mStale = 1'b0;
               end else begin
                  mStale = 1'b1;
               end
            end
         end else begin
            deqNow = !expStall && !depStall;
            if (deqNow) void'(mq.pop_front());
            if (mOut && I_MemValid) begin
               if (!mStale) begin
                  e.pc = mReqAddr + 16'd4;
                  e.ir = I_MemData;
                  mq.push_back(e);
               end
               mOut = 1'b0;
               mStale = 1'b0;
            end
            if (expReq) begin
               mOut = 1'b1;
               mReqAddr = mFetchPc;
               mFetchPc = mFetchPc + 16'd4;
            end
         end
      end
   endtask

   task automatic resetBurst(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1);
   endtask

   initial begin
      int guard;
      logic [PW-1:0] rpc;
      I_RESET = 1'b1;
      I_BranchAddrSelect = 1'b0;
      I_BranchPC = '0;
      I_BranchStallSignal = 1'b0;
      I_DepStallSignal = 1'b0;
      I_MemValid = 1'b0;
      I_MemData = '0;
      mOut = 1'b0;
      mStale = 1'b0;
      mFetchPc = RESET_PC;
      mReqAddr = RESET_PC;
      mStallCnt = 0;
      resetBurst(4);

      // Streaming with latency 1, then decode backpressure and release.
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
      checkOutput("queueFilled", mq.size(), DEPTH);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);

      // Redirect to 0x40 while the request to 0x8 is in flight.
      resetBurst(4);
      guard = 0;
      while (!(mOut && mReqAddr == 16'h0008 && dueQ.size() > 0 && dueQ[0] > cycle + 1) && guard < 40) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3);
         guard++;
      end
      checkOutput("redirectSetup", guard < 40, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 3);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2);

      // Redirect coinciding with a response and a head dequeue.
      guard = 0;
      while (!(mOut && !mStale && mq.size() > 0 && dueQ.size() > 0 && dueQ[0] == cycle + 1) && guard < 40) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2);
         guard++;
      end
      checkOutput("collideSetup", guard < 40, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
      checkOutput("collideEmpty", O_FetchStall, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);

      // Fetch PC wraps past 0xFFFC.
      applyStimulus(1'b0, 1'b1, 16'hFFF8, 1'b0, 1'b0, 1);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);

      // Response to a request outstanding across reset lands in the first cycle after reset.
      resetBurst(4);
      guard = 0;
      while (!mOut && guard < 10) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3);
         guard++;
      end
      checkOutput("staleSetup", mOut, 1'b1);
      resetBurst(2);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);

`ifdef FETCH_QUEUE_STATS_EN
      resetBurst(4);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
      @(negedge I_CLOCK);
      #1;
      checkOutput("stallCount5", O_StallCount, 16'd5);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1);
      @(negedge I_CLOCK);
      #1;
      checkOutput("stallCountClr", O_StallCount, 16'd0);
      resetBurst(3);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            resetBurst(4);
         end else begin
            rpc = 16'($urandom);
            rpc[1:0] = 2'b00;
            applyStimulus(1'b0, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(1, 3));
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
